// File: rtl/region_probe.sv
// region_probe: scans an XDIM x YDIM region of a framebuffer, starting at
// (x0,y0), and counts the pixels whose colour equals match_colour. Pixels
// that fall off-screen are skipped without a read, but the scan always
// takes XDIM*YDIM cycles.
//
// Ports:
//   clk, reset            sole clock; synchronous active-high reset
//   start                 probe request, accepted only when idle
//   x0, y0, match_colour  region origin and colour, captured on accept
//   rd_en, rd_x, rd_y     framebuffer read request (registered)
//   rd_colour             read data, valid the cycle after rd_en
//   busy                  high while scanning or draining
//   done                  one-cycle completion pulse
//   hit, hit_count        any-match flag and saturating match count
//   first_x, first_y      first matching pixel in raster order
module region_probe #(
    parameter int XDIM    = 10,
    parameter int YDIM    = 10,
    parameter int XSCREEN = 160,
    parameter int YSCREEN = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] x0,
    input  logic [6:0] y0,
    input  logic [2:0] match_colour,
    output logic       rd_en,
    output logic [7:0] rd_x,
    output logic [6:0] rd_y,
    input  logic [2:0] rd_colour,
    output logic       busy,
    output logic       done,
    output logic       hit,
    output logic [6:0] hit_count,
    output logic [7:0] first_x,
    output logic [6:0] first_y
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    localparam logic [7:0] XLAST = 8'(XDIM - 1);
    localparam logic [6:0] YLAST = 7'(YDIM - 1);
    localparam logic [8:0] XLIM  = 9'(XSCREEN);
    localparam logic [7:0] YLIM  = 8'(YSCREEN);

    state_t     state, state_next;

    logic [7:0] cap_x;
    logic [6:0] cap_y;
    logic [2:0] cap_colour;
    logic [7:0] xc;
    logic [6:0] yc;
    logic       drain_last;

    // Compare stage: address of the read issued on the previous cycle.
    logic       pend_v;
    logic [7:0] pend_x;
    logic [6:0] pend_y;

    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic       on_screen;
    logic       accept;
    logic       scan_last;
    logic       match;

    // One bit wider than the port so a wrap past 255/127 still clips.
    assign sum_x     = {1'b0, cap_x} + {1'b0, xc};
    assign sum_y     = {1'b0, cap_y} + {1'b0, yc};
    assign on_screen = (sum_x < XLIM) && (sum_y < YLIM);
    assign match     = pend_v && (rd_colour == cap_colour);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        scan_last  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (xc == XLAST && yc == YLAST) begin
                    scan_last  = 1'b1;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                // Two cycles: one for the last registered request to reach
                // the framebuffer, one for its data to be compared.
                if (drain_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_x      <= '0;
            cap_y      <= '0;
            cap_colour <= '0;
            xc         <= '0;
            yc         <= '0;
            drain_last <= 1'b0;
            pend_v     <= 1'b0;
            pend_x     <= '0;
            pend_y     <= '0;
            rd_en      <= 1'b0;
            rd_x       <= '0;
            rd_y       <= '0;
            hit        <= 1'b0;
            hit_count  <= '0;
            first_x    <= '0;
            first_y    <= '0;
        end else begin
            drain_last <= (state == DRAIN) && !drain_last;
            pend_v     <= rd_en;
            pend_x     <= rd_x;
            pend_y     <= rd_y;
            rd_en      <= 1'b0;

            if (match) begin
                hit <= 1'b1;
                if (hit_count != '1) begin
                    hit_count <= hit_count + 7'd1;
                end
                if (!hit) begin
                    first_x <= pend_x;
                    first_y <= pend_y;
                end
            end

            if (state == SCAN) begin
                rd_en <= on_screen;
                if (on_screen) begin
                    rd_x <= sum_x[7:0];
                    rd_y <= sum_y[6:0];
                end
                if (!scan_last) begin
                    if (xc == XLAST) begin
                        xc <= '0;
                        yc <= yc + 7'd1;
                    end else begin
                        xc <= xc + 8'd1;
                    end
                end
            end

            if (accept) begin
                cap_x      <= x0;
                cap_y      <= y0;
                cap_colour <= match_colour;
                xc         <= '0;
                yc         <= '0;
                hit        <= 1'b0;
                hit_count  <= '0;
                first_x    <= '0;
                first_y    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_region_probe.sv
module tb_region_probe;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [2:0] match_colour;
    logic       rd_en;
    logic [7:0] rd_x;
    logic [6:0] rd_y;
    logic [2:0] rd_colour = 3'd0;
    logic       busy, done, hit;
    logic [6:0] hit_count;
    logic [7:0] first_x;
    logic [6:0] first_y;

    // Second instance, 12x12 region, used to reach the 127 saturation point.
    logic       b_start;
    logic [7:0] b_x0;
    logic [6:0] b_y0;
    logic [2:0] b_colour;
    logic       b_rd_en;
    logic [7:0] b_rd_x;
    logic [6:0] b_rd_y;
    logic [2:0] b_rd_colour = 3'd0;
    logic       b_busy, b_done, b_hit;
    logic [6:0] b_hit_count;
    logic [7:0] b_first_x;
    logic [6:0] b_first_y;

    int n_checks = 0;
    int n_fail   = 0;
    int ram_mode = 0;
    int rd_cnt   = 0;
    int bad_cnt  = 0;
    int done_cnt = 0;

    region_probe dut (
        .clk(clk), .reset(reset), .start(start), .x0(x0), .y0(y0),
        .match_colour(match_colour), .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y),
        .rd_colour(rd_colour), .busy(busy), .done(done), .hit(hit),
        .hit_count(hit_count), .first_x(first_x), .first_y(first_y)
    );

    region_probe #(.XDIM(12), .YDIM(12)) big (
        .clk(clk), .reset(reset), .start(b_start), .x0(b_x0), .y0(b_y0),
        .match_colour(b_colour), .rd_en(b_rd_en), .rd_x(b_rd_x), .rd_y(b_rd_y),
        .rd_colour(b_rd_colour), .busy(b_busy), .done(b_done), .hit(b_hit),
        .hit_count(b_hit_count), .first_x(b_first_x), .first_y(b_first_y)
    );

    always #5 clk = ~clk;

    // mode 0: 10x10 block of colour 4 at (30,30); mode 1: all 7; mode 2: all 0
    function automatic logic [2:0] pix(input int mode, input logic [7:0] x, input logic [6:0] y);
        if (mode == 0) return (x >= 30 && x < 40 && y >= 30 && y < 40) ? 3'd4 : 3'd0;
        if (mode == 1) return 3'd7;
        return 3'd0;
    endfunction

    always @(posedge clk) begin
        if (rd_en) rd_colour <= pix(ram_mode, rd_x, rd_y);
        if (b_rd_en) b_rd_colour <= 3'd7;
    end

    always @(negedge clk) begin
        if (rd_en) begin
            rd_cnt = rd_cnt + 1;
            if (rd_x >= 160 || rd_y >= 120) bad_cnt = bad_cnt + 1;
        end
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 400) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_probe(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                             output int lat, output int rds, output int bads);
        int r0, b0;
        tick();
        x0 = x; y0 = y; match_colour = c; start = 1'b1;
        tick();
        start = 1'b0;
        r0 = rd_cnt;
        b0 = bad_cnt;
        check("busy_after_accept", int'(busy), 1);
        wait_done(lat);
        rds  = rd_cnt - r0;
        bads = bad_cnt - b0;
    endtask

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        int         mode;
        int         hit;
        int         cnt;
        int         fx;
        int         fy;
        int         rds;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int lat, rds, bads, d0;

        vecs[0] = '{8'd25,  7'd25,  3'd4, 0, 1, 25,  30,  30,  100};
        vecs[1] = '{8'd80,  7'd60,  3'd4, 0, 0, 0,   0,   0,   100};
        vecs[2] = '{8'd155, 7'd115, 3'd7, 1, 1, 25,  155, 115, 25};
        vecs[3] = '{8'd0,   7'd0,   3'd0, 2, 1, 100, 0,   0,   100};
        vecs[4] = '{8'd35,  7'd35,  3'd4, 0, 1, 25,  35,  35,  100};
        vecs[5] = '{8'd30,  7'd30,  3'd0, 0, 0, 0,   0,   0,   100};
        vecs[6] = '{8'd150, 7'd110, 3'd7, 1, 1, 100, 150, 110, 100};
        vecs[7] = '{8'd151, 7'd111, 3'd7, 1, 1, 81,  151, 111, 81};
        vecs[8] = '{8'd250, 7'd0,   3'd7, 1, 0, 0,   0,   0,   0};
        vecs[9] = '{8'd0,   7'd125, 3'd7, 1, 0, 0,   0,   0,   0};

        reset = 1'b1; start = 1'b0; x0 = '0; y0 = '0; match_colour = '0;
        b_start = 1'b0; b_x0 = '0; b_y0 = '0; b_colour = '0;
        repeat (3) tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rd_en", int'(rd_en), 0);
        check("rst_hit", int'(hit), 0);
        check("rst_count", int'(hit_count), 0);
        check("rst_first", int'({first_x, first_y}), 0);
        check("rst_rd_addr", int'({rd_x, rd_y}), 0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            ram_mode = vecs[i].mode;
            run_probe(vecs[i].x, vecs[i].y, vecs[i].c, lat, rds, bads);
            check($sformatf("v%0d_latency", i), lat, 102);
            check($sformatf("v%0d_busy_in_done", i), int'(busy), 0);
            check($sformatf("v%0d_hit", i), int'(hit), vecs[i].hit);
            check($sformatf("v%0d_count", i), int'(hit_count), vecs[i].cnt);
            check($sformatf("v%0d_first_x", i), int'(first_x), vecs[i].fx);
            check($sformatf("v%0d_first_y", i), int'(first_y), vecs[i].fy);
            check($sformatf("v%0d_rd_pulses", i), rds, vecs[i].rds);
            check($sformatf("v%0d_offscreen_rd", i), bads, 0);
            tick();
            check($sformatf("v%0d_done_pulse", i), int'(done), 0);
            repeat (2) tick();
            check($sformatf("v%0d_count_hold", i), int'(hit_count), vecs[i].cnt);
        end

        // Start re-pulsed mid-scan with a different origin must be ignored.
        ram_mode = 2;
        tick();
        x0 = 8'd0; y0 = 7'd0; match_colour = 3'd0; start = 1'b1;
        tick();
        start = 1'b0;
        d0 = done_cnt;
        repeat (20) tick();
        x0 = 8'd50; y0 = 7'd50; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 21;
        while (!done && lat < 400) begin
            tick();
            lat++;
        end
        check("restart_latency", lat, 102);
        check("restart_count", int'(hit_count), 100);
        check("restart_first_x", int'(first_x), 0);
        repeat (150) tick();
        check("restart_single_done", done_cnt - d0, 1);
        check("restart_idle", int'(busy), 0);

        // Reset in the middle of a scan, after three matches have landed.
        ram_mode = 0;
        tick();
        x0 = 8'd25; y0 = 7'd25; match_colour = 3'd4; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (60) tick();
        check("pre_reset_count", int'(hit_count), 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_rd_en", int'(rd_en), 0);
        check("mid_rst_hit", int'(hit), 0);
        check("mid_rst_count", int'(hit_count), 0);
        check("mid_rst_first", int'({first_x, first_y}), 0);
        repeat (3) tick();
        check("mid_rst_count_late", int'(hit_count), 0);
        check("mid_rst_stays_idle", int'(busy), 0);
        run_probe(8'd25, 7'd25, 3'd4, lat, rds, bads);
        check("post_rst_latency", lat, 102);
        check("post_rst_count", int'(hit_count), 25);
        check("post_rst_first_x", int'(first_x), 30);

        // Back-to-back probes with start held high.
        tick();
        x0 = 8'd25; y0 = 7'd25; match_colour = 3'd4; start = 1'b1;
        tick();
        x0 = 8'd35; y0 = 7'd35;
        wait_done(lat);
        check("b2b_first_latency", lat, 102);
        check("b2b_first_count", int'(hit_count), 25);
        check("b2b_first_x", int'(first_x), 30);
        tick();
        check("b2b_idle_busy", int'(busy), 0);
        check("b2b_idle_done", int'(done), 0);
        tick();
        start = 1'b0;
        check("b2b_second_busy", int'(busy), 1);
        check("b2b_cleared_count", int'(hit_count), 0);
        check("b2b_cleared_hit", int'(hit), 0);
        check("b2b_cleared_first", int'({first_x, first_y}), 0);
        wait_done(lat);
        check("b2b_second_latency", lat, 102);
        check("b2b_second_count", int'(hit_count), 25);
        check("b2b_second_first_x", int'(first_x), 35);
        check("b2b_second_first_y", int'(first_y), 35);

        // 12x12 all-match region: 144 matches saturate at 127.
        tick();
        b_x0 = 8'd0; b_y0 = 7'd0; b_colour = 3'd7; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        lat = 0;
        while (!b_done && lat < 400) begin
            tick();
            lat++;
        end
        check("sat_latency", lat, 146);
        check("sat_hit", int'(b_hit), 1);
        check("sat_count", int'(b_hit_count), 127);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
